// File: rtl/aes_pkg.sv
// AES-128 constants and byte/word helpers shared by the pipelined cipher core.
// Byte 0 of a 128-bit state sits in bits [127:120]; columns are 32-bit words, MSB first.
package aes_pkg;

  typedef logic [127:0] state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_round_stage.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// The next round key is expanded here from the previous one so each block carries its own key.
module aes_round_stage
  import aes_pkg::*;
#(
  parameter int ROUND = 1,
  parameter bit FINAL = 1'b0
) (
  input  logic [127:0] state_i,
  input  logic [127:0] rkey_i,
  output logic [127:0] state_o,
  output logic [127:0] rkey_o
);

  logic [31:0] kt;
  state_t      sr;
  state_t      mc;

  assign kt = sub_word(rot_word(rkey_i[31:0])) ^ {RCON[ROUND], 24'h0};
  assign rkey_o[127:96] = rkey_i[127:96] ^ kt;
  assign rkey_o[95:64]  = rkey_i[95:64]  ^ rkey_o[127:96];
  assign rkey_o[63:32]  = rkey_i[63:32]  ^ rkey_o[95:64];
  assign rkey_o[31:0]   = rkey_i[31:0]   ^ rkey_o[63:32];

  // Row r of output column c takes the substituted byte from input column (c+r) mod 4.
  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(r+4*c) -: 8] = SBOX[state_i[127-8*(r+4*((c+r)%4)) -: 8]];
      end
    end
  end

  generate
    if (FINAL) begin : g_final
      assign mc = sr;
    end else begin : g_mix
      always_comb begin
        mc = '0;
        for (int c = 0; c < 4; c++) begin
          mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
        end
      end
    end
  endgenerate

  assign state_o = mc ^ rkey_o;

endmodule

// File: rtl/aes_top.sv
// Fully pipelined AES-128 encryptor: 12 register stages, one block per clock, 11-edge latency.
// A valid bit travels with each slot so flushed or zero-filled slots present 0 on cryptokey.
module aes_top
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic [127:0] cryptokey
);

  state_t      st_q [0:10];
  state_t      rk_q [0:9];
  state_t      st_d [1:10];
  state_t      rk_d [1:10];
  logic [10:0] vld_q;
  state_t      cryptokey_q;

  generate
    for (genvar i = 1; i <= 10; i++) begin : g_round
      aes_round_stage #(
        .ROUND (i),
        .FINAL (i == 10)
      ) u_round (
        .state_i (st_q[i-1]),
        .rkey_i  (rk_q[i-1]),
        .state_o (st_d[i]),
        .rkey_o  (rk_d[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= 10; i++) st_q[i] <= '0;
      for (int i = 0; i <= 9; i++)  rk_q[i] <= '0;
      vld_q       <= '0;
      cryptokey_q <= '0;
    end else begin
      st_q[0] <= data_in ^ key;
      rk_q[0] <= key;
      for (int i = 1; i <= 10; i++) st_q[i] <= st_d[i];
      for (int i = 1; i <= 9; i++)  rk_q[i] <= rk_d[i];
      vld_q       <= {vld_q[9:0], 1'b1};
      cryptokey_q <= vld_q[10] ? st_q[10] : '0;
    end
  end

  assign cryptokey = cryptokey_q;

endmodule

// File: tb/tb_aes_top.sv
// Randomised bench for aes_top against a byte-level FIPS-197 model with an arithmetic S-box.
module tb_aes_top;

  logic         clk;
  logic         reset;
  logic [127:0] data_in;
  logic [127:0] key;
  logic [127:0] cryptokey;

  logic         lit_vld;
  logic [127:0] lit_val;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] ct_h   [4096];
  logic         lv_h   [4096];
  logic [127:0] lt_h   [4096];
  int           last_rst = 0;

  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] K2  = 128'h0f1571c947d9e8590cb7add6af7f6798;
  localparam logic [127:0] CT2 = 128'hff0b844a0853bf7c6934ab4364148fb9;
  localparam logic [127:0] CTZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_top dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .key       (key),
    .cryptokey (cryptokey)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r+4*c] = sbox_t[s[r+4*((c+r)%4)]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rnd < 10)
            s[r+4*c] = gmul(8'h02, t[4*c+r]) ^ gmul(8'h03, t[4*c+(r+1)%4]) ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
          else
            s[r+4*c] = t[r+4*c];
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*rnd + n/4][31-8*(n%4) -: 8];
    end
    res = '0;
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
    return res;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [127:0] d, input logic [127:0] k,
                       input logic lv, input logic [127:0] lt);
    @(negedge clk);
    reset   = rst;
    data_in = d;
    key     = k;
    lit_vld = lv;
    lit_val = lt;
  endtask

  task automatic drive_rand(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
  endtask

  // Compare process: a block captured at edge e-11 must appear at edge e unless a reset intervened.
  initial begin
    logic [7:0]   inv, b;
    logic [127:0] exp;
    int           e;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      b = inv;
      sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    e = 0;
    forever begin
      @(posedge clk);
      if (reset) last_rst = e;
      ct_h[e] = aes_enc(data_in, key);
      lv_h[e] = lit_vld;
      lt_h[e] = lit_val;
      #1;
      exp = (e >= 11 && last_rst < e - 11) ? ct_h[e-11] : 128'h0;
      check($sformatf("cryptokey@edge%0d", e), cryptokey, exp);
      if (e >= 11 && last_rst < e - 11 && lv_h[e-11])
        check($sformatf("literal@edge%0d", e), cryptokey, lt_h[e-11]);
      e++;
    end
  end

  initial begin
    reset = 1'b1; data_in = '0; key = '0; lit_vld = 1'b0; lit_val = '0;
    drive(1'b1, '0, '0, 1'b0, '0);
    drive(1'b1, PT1, K1, 1'b0, '0);
    check("model_c1",   aes_enc(PT1, K1), CT1);
    check("model_vec2", aes_enc(PT2, K2), CT2);
    check("model_zero", aes_enc('0, '0), CTZ);

    drive_rand(3);
    drive(1'b0, PT1, K1, 1'b1, CT1);
    drive(1'b0, PT2, K2, 1'b1, CT2);
    drive(1'b0, '0, '0, 1'b1, CTZ);
    drive_rand(12);

    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) drive(1'b0, PT2, K2, 1'b1, CT2);
      else            drive(1'b0, PT1, K1, 1'b1, CT1);
    end
    drive_rand(40);

    drive_rand(5);
    drive(1'b1, PT2, K2, 1'b0, '0);
    drive(1'b0, PT1, K1, 1'b1, CT1);
    drive(1'b0, PT2, K2, 1'b1, CT2);
    drive_rand(30);
    drive(1'b0, '0, '0, 1'b1, CTZ);
    drive_rand(14);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
